// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multi-digit 7-segment scan controller.
//
// Time-multiplexes NUM_DIGITS hex nibbles onto one shared, active-low segment
// bus. The block has its own refresh prescaler, hex decoding, per-digit
// blanking and decimal points. New values are staged by 'load' and moved into
// the display registers only at a frame boundary, so a digit never tears
// mid-scan.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   data_in      nibble k in [4k+3:4k]; digit 0 is rightmost
//   dp_in        decimal point request per digit, 1 = lit
//   blank_in     1 = digit k dark
//   load         capture data_in/dp_in/blank_in
//   an           anode enables, active-low (registered)
//   seg          {g,f,e,d,c,b,a}, active-low (registered)
//   dp           decimal point, active-low (registered)
//   digit_idx    digit currently being scanned
//   frame_done   one-cycle pulse following each full scan
//   upd_pending  staged load waiting for the frame boundary
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int IDX_W       = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done,
  output logic                    upd_pending
);

  localparam int PRE_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] ONE_D  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [PRE_W-1:0]      prescaler_r;
  logic [IDX_W-1:0]      digit_idx_r;
  logic                  frame_done_r;
  logic                  upd_pending_r;
  logic [DATA_W-1:0]     stage_data_r;
  logic [NUM_DIGITS-1:0] stage_dp_r;
  logic [NUM_DIGITS-1:0] stage_blank_r;
  logic [DATA_W-1:0]     disp_data_r;
  logic [NUM_DIGITS-1:0] disp_dp_r;
  logic [NUM_DIGITS-1:0] disp_blank_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic [6:0]            seg_r;
  logic                  dp_r;

  logic                  tick_s;
  logic                  boundary_s;
  logic [3:0]            nibble_s;
  logic [NUM_DIGITS-1:0] an_next_s;
  logic [6:0]            seg_next_s;
  logic                  dp_next_s;

  assign tick_s     = (prescaler_r == PRE_MAX);
  assign boundary_s = tick_s && (digit_idx_r == IDX_MAX);
  assign nibble_s   = disp_data_r[digit_idx_r*4 +: 4];

  // Next output pattern; the tick cycle is a dark guard so the old digit's
  // segments never ghost onto the newly selected anode.
  always_comb begin
    an_next_s  = AN_OFF;
    seg_next_s = 7'h7F;
    dp_next_s  = 1'b1;
    if (tick_s) begin
      an_next_s  = AN_OFF;
      seg_next_s = 7'h7F;
      dp_next_s  = 1'b1;
    end else if (disp_blank_r[digit_idx_r]) begin
      an_next_s  = AN_OFF;
      seg_next_s = 7'h7F;
      dp_next_s  = 1'b1;
    end else begin
      an_next_s  = ~(ONE_D << digit_idx_r);
      seg_next_s = hex_to_seg(nibble_s);
      dp_next_s  = ~disp_dp_r[digit_idx_r];
    end
  end

  // Prescaler, digit index and frame-done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_r  <= {PRE_W{1'b0}};
      digit_idx_r  <= {IDX_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= boundary_s;
      if (tick_s) begin
        prescaler_r <= {PRE_W{1'b0}};
        digit_idx_r <= boundary_s ? {IDX_W{1'b0}} : digit_idx_r + IDX_W'(1);
      end else begin
        prescaler_r <= prescaler_r + PRE_W'(1);
      end
    end
  end

  // Load staging and frame-synchronous transfer to the display registers.
  // A load coinciding with the boundary bypasses staging so the newest value
  // wins over anything older still pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_pending_r <= 1'b0;
      stage_data_r  <= {DATA_W{1'b0}};
      stage_dp_r    <= {NUM_DIGITS{1'b0}};
      stage_blank_r <= {NUM_DIGITS{1'b0}};
      disp_data_r   <= {DATA_W{1'b0}};
      disp_dp_r     <= {NUM_DIGITS{1'b0}};
      disp_blank_r  <= {NUM_DIGITS{1'b0}};
    end else if (load) begin
      stage_data_r  <= data_in;
      stage_dp_r    <= dp_in;
      stage_blank_r <= blank_in;
      if (boundary_s) begin
        disp_data_r   <= data_in;
        disp_dp_r     <= dp_in;
        disp_blank_r  <= blank_in;
        upd_pending_r <= 1'b0;
      end else begin
        upd_pending_r <= 1'b1;
      end
    end else if (boundary_s && upd_pending_r) begin
      disp_data_r   <= stage_data_r;
      disp_dp_r     <= stage_dp_r;
      disp_blank_r  <= stage_blank_r;
      upd_pending_r <= 1'b0;
    end else begin
      upd_pending_r <= upd_pending_r;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r  <= AN_OFF;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
    end
  end

  assign an          = an_r;
  assign seg         = seg_r;
  assign dp          = dp_r;
  assign digit_idx   = digit_idx_r;
  assign frame_done  = frame_done_r;
  assign upd_pending = upd_pending_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with REFRESH_DIV=4, NUM_DIGITS=4.
// 'cyc' counts rising edges since reset release; outputs are sampled 1 time
// unit after each rising edge and inputs are changed at the same point.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4*ND-1:0] data_in = 16'h0000;
  logic [ND-1:0] dp_in = 4'b0000;
  logic [ND-1:0] blank_in = 4'b0000;
  logic          load = 1'b0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic [IW-1:0] digit_idx;
  logic          frame_done;
  logic          upd_pending;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .an(an), .seg(seg), .dp(dp),
    .digit_idx(digit_idx), .frame_done(frame_done), .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  initial begin
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         d;

    // Reset state while reset is held.
    #12;
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_seg", seg, 7'h7F);
    check_eq("rst_dp", dp, 1'b1);
    check_eq("rst_idx", digit_idx, 2'd0);
    check_eq("rst_pend", upd_pending, 1'b0);
    check_eq("rst_fd", frame_done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;

    // Scan order, guard cycles, frame_done and index wrap over two frames.
    for (int n = 1; n <= 32; n++) begin
      step();
      d = (n / 4) % 4;
      exp_an  = (n % 4 == 0) ? 4'hF : ~(4'b0001 << ((n / 4) % 4));
      exp_seg = (n % 4 == 0) ? 7'h7F : 7'h40;
      check_eq("scan_an", an, exp_an);
      check_eq("scan_seg", seg, exp_seg);
      check_eq("scan_dp", dp, 1'b1);
      check_eq("scan_idx", digit_idx, d);
      check_eq("scan_fd", frame_done, (n % 16 == 0) ? 1'b1 : 1'b0);
      check_eq("scan_pend", upd_pending, 1'b0);
    end

    // Decode: stage 1A8F, applied at the edge-48 boundary.
    data_in = 16'h1A8F;
    load = 1'b1;
    step();
    load = 1'b0;
    check_eq("dec_pend", upd_pending, 1'b1);
    check_eq("dec_hold", seg, 7'h40);
    run_to(48);
    check_eq("dec_fd", frame_done, 1'b1);
    check_eq("dec_pclr", upd_pending, 1'b0);
    run_to(49);
    check_eq("dec_d0", seg, 7'h0E);
    run_to(53);
    check_eq("dec_d1", seg, 7'h00);
    run_to(57);
    check_eq("dec_d2", seg, 7'h08);
    run_to(61);
    check_eq("dec_d3", seg, 7'h79);

    // Tear-free: mid-frame load of 1234 shows only after the edge-80 boundary.
    run_to(66);
    data_in = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    check_eq("tear_pend", upd_pending, 1'b1);
    check_eq("tear_d0_old", seg, 7'h0E);
    run_to(70);
    check_eq("tear_d1_old", seg, 7'h00);
    run_to(79);
    check_eq("tear_d3_old", seg, 7'h79);
    check_eq("tear_pend2", upd_pending, 1'b1);
    run_to(81);
    check_eq("tear_d0_new", seg, 7'h19);
    check_eq("tear_pclr", upd_pending, 1'b0);
    run_to(85);
    check_eq("tear_d1_new", seg, 7'h30);

    // Collision: 0000 staged, then FFFF loaded on the edge-96 boundary.
    data_in = 16'h0000;
    load = 1'b1;
    step();
    load = 1'b0;
    check_eq("col_pend", upd_pending, 1'b1);
    run_to(95);
    data_in = 16'hFFFF;
    load = 1'b1;
    step();
    load = 1'b0;
    check_eq("col_pclr", upd_pending, 1'b0);
    check_eq("col_fd", frame_done, 1'b1);
    run_to(97);
    check_eq("col_d0", seg, 7'h0E);
    run_to(101);
    check_eq("col_d1", seg, 7'h0E);
    run_to(105);
    check_eq("col_d2", seg, 7'h0E);
    run_to(109);
    check_eq("col_d3", seg, 7'h0E);

    // Blank digit 2, decimal point on digit 0; applied at edge 112.
    blank_in = 4'b0100;
    dp_in = 4'b0001;
    load = 1'b1;
    step();
    load = 1'b0;
    run_to(111);
    check_eq("bl_before_an", an, 4'h7);
    check_eq("bl_before_dp", dp, 1'b1);
    run_to(112);
    for (int n = 113; n <= 128; n++) begin
      step();
      d = (n / 4) % 4;
      if (n % 4 == 0 || d == 2) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(4'b0001 << d);
        exp_seg = 7'h0E;
      end
      exp_dp = (n % 4 != 0 && d == 0) ? 1'b0 : 1'b1;
      check_eq("bl_an", an, exp_an);
      check_eq("bl_an2", an[2], 1'b1);
      check_eq("bl_seg", seg, exp_seg);
      check_eq("bl_dp", dp, exp_dp);
    end

    // Mid-scan reset with a load pending.
    blank_in = 4'b0000;
    dp_in = 4'b0000;
    run_to(129);
    data_in = 16'h5555;
    load = 1'b1;
    step();
    load = 1'b0;
    check_eq("mr_pend_pre", upd_pending, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("mr_an", an, 4'hF);
    check_eq("mr_seg", seg, 7'h7F);
    check_eq("mr_dp", dp, 1'b1);
    check_eq("mr_idx", digit_idx, 2'd0);
    check_eq("mr_pend", upd_pending, 1'b0);
    check_eq("mr_fd", frame_done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check_eq("post_idx", digit_idx, 2'd0);
    check_eq("post_pend", upd_pending, 1'b0);
    check_eq("post_an", an, 4'hE);
    check_eq("post_seg", seg, 7'h40);
    check_eq("post_dp", dp, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised multi-digit 7-segment scan controller; successor to the 4-to-1 address/data display mux.
- Time-multiplexes NUM_DIGITS hex nibbles onto one shared segment bus with its own refresh prescaler, hex decoding, per-digit blanking and decimal points.
- Double-buffered, frame-synchronous update prevents digit tearing.
- Sits between the datapath/debug registers and the board's anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 100000, clock cycles per digit slot (>=2).
- IDX_W, 2, digit index width; must satisfy 2**IDX_W >= NUM_DIGITS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- data_in  in  4*NUM_DIGITS  nibble k in [4k+3:4k]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- blank_in  in  NUM_DIGITS  1 = digit k dark
- load  in  1  request to capture data_in/dp_in/blank_in
- an  out  NUM_DIGITS  anode enables, active-low
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- digit_idx  out  IDX_W  digit currently driven
- frame_done  out  1  one-cycle pulse at end of each full scan
- upd_pending  out  1  staged load waiting for frame boundary

Behaviour:
- Reset (async, immediate):
  - Prescaler=0, digit_idx=0.
  - Staging and display registers all 0; blank bits 0.
  - upd_pending=0, frame_done=0.
  - an all 1s, seg=7'h7F, dp=1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1).
- Digit index:
  - On a tick edge, digit_idx increments.
  - At NUM_DIGITS-1 it wraps to 0; that wrap edge is the frame boundary.
- frame_done: registered; high for the one cycle following a frame-boundary edge.
- Load handshake:
  - load=1 with no boundary this edge: capture inputs into staging, set upd_pending=1.
  - Frame-boundary edge with upd_pending=1 and load=0: staging -> display registers, clear upd_pending.
  - load=1 on a frame-boundary edge: data_in/dp_in/blank_in go directly into the display registers. Staging is updated too; upd_pending cleared.
  - Repeated loads before the boundary: last value wins.
  - Display registers never change outside a frame boundary.
- Outputs (all registered, one cycle after the index/display state they reflect):
  - Ghost guard: on a tick edge, an <= all 1s and seg <= 7'h7F for exactly one cycle.
  - Otherwise an <= ~(one-hot digit_idx), with bit forced 1 if that digit's display blank bit is set.
  - Otherwise seg <= hex decode of the display nibble at digit_idx. seg <= 7'h7F if that digit is blanked.
  - dp <= ~display_dp[digit_idx], forced 1 during guard or blank.
- Hex decode, seg values:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, b=03, C=46, d=21, E=06, F=0E
- Slot length:
  - Each digit is lit for REFRESH_DIV-1 cycles per slot.
  - Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- Reset mid-scan: all state returns to reset values within the same cycle; a pending load is discarded.

Test Plan:
- Reset: reset high mid-scan -> an=4'hF, seg=7'h7F, dp=1, digit_idx=0, upd_pending=0 immediately, and still so 1 cycle after release.
- Scan order (REFRESH_DIV=4, NUM_DIGITS=4):
  - an cycles E,D,B,7 with one F guard cycle per slot.
  - frame_done pulses every 16 cycles.
  - digit_idx wraps 3->0.
- Decode: load data_in=16'h1A8F at reset, wait one frame boundary -> seg shows 0E, 00, 08, 79 on digits 0..3.
- Tear-free update:
  - Load 16'h1234 mid-frame -> upd_pending=1; segments unchanged until the boundary.
  - Then digit 0 shows 7'h19 (4); upd_pending=0.
- Boundary collision: load=1 on the frame-boundary edge with 16'hFFFF while older staged 16'h0000 is pending -> display all F (7'h0E), upd_pending=0.
- Blank/dp: blank_in=4'b0100, dp_in=4'b0001 -> digit 2 anode never low and seg=7'h7F in its slot; dp=0 only in digit 0's slot.
